trick_table_arbiter: RTL and testbench

Shares one sin/cos lookup table (trick_table, 2^ANGLE_WIDTH entries) between two requesters. Each requester has its own valid/ready request channel and response channel. A round-robin arbiter grants one request per cycle. The granted request passes through a two-stage registered pipeline (angle register, then table output register) with full backpressure. The block sits between the NCO/test-pattern engines and the single table instance.

---
 rtl/trick_pkg.sv | 10 +
 rtl/trick_table.sv | 33 +++
 rtl/trick_table_arbiter.sv | 93 +++++++++
 tb/tb_trick_table_arbiter.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/trick_pkg.sv
// Shared constants for the sin/cos table and its requesters.
package trick_pkg;
  localparam int VALUE_WIDTH = 33;
  localparam int ANGLE_WIDTH = 10;
  localparam int COUNT       = 2 ** ANGLE_WIDTH;

  typedef logic req_id_t;
  localparam req_id_t REQ_NCO = 1'b0;
  localparam req_id_t REQ_TPG = 1'b1;
endpackage

// File: rtl/trick_table.sv
// Combinational full-turn sin/cos ROM. Entries are round(sin/cos * (2^(W-1)-1)),
// and the elaboration-time constant function fills both tables.
module trick_table #(
  parameter int VALUE_WIDTH = trick_pkg::VALUE_WIDTH,
  parameter int ANGLE_WIDTH = trick_pkg::ANGLE_WIDTH
) (
  input  logic [ANGLE_WIDTH-1:0] angle,
  output logic [VALUE_WIDTH-1:0] sin_value,
  output logic [VALUE_WIDTH-1:0] cos_value
);
  localparam int  COUNT = 2 ** ANGLE_WIDTH;
  localparam real PI    = 3.14159265358979323846;
  localparam real AMP   = 2.0 ** (VALUE_WIDTH - 1) - 1.0;

  function automatic logic [VALUE_WIDTH-1:0] wave(input int idx, input bit use_cos);
    real ph;
    real v;
    ph = 2.0 * PI * real'(idx) / real'(COUNT);
    v  = use_cos ? $cos(ph) : $sin(ph);
    return VALUE_WIDTH'(longint'(AMP * v));
  endfunction

  logic [VALUE_WIDTH-1:0] sin_rom [COUNT];
  logic [VALUE_WIDTH-1:0] cos_rom [COUNT];

  for (genvar i = 0; i < COUNT; i++) begin : g_rom
    assign sin_rom[i] = wave(i, 1'b0);
    assign cos_rom[i] = wave(i, 1'b1);
  end

  assign sin_value = sin_rom[angle];
  assign cos_value = cos_rom[angle];
endmodule

// File: rtl/trick_table_arbiter.sv
// Round-robin share of one trick_table between two requesters, behind a
// two-stage (angle, table output) pipeline with full valid/ready backpressure.
module trick_table_arbiter #(
  parameter int VALUE_WIDTH = trick_pkg::VALUE_WIDTH,
  parameter int ANGLE_WIDTH = trick_pkg::ANGLE_WIDTH,
  parameter int NREQ        = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NREQ-1:0]             req_valid,
  output logic [NREQ-1:0]             req_ready,
  input  logic [NREQ*ANGLE_WIDTH-1:0] req_angle,
  output logic [NREQ-1:0]             rsp_valid,
  input  logic [NREQ-1:0]             rsp_ready,
  output logic [VALUE_WIDTH-1:0]      rsp_sin,
  output logic [VALUE_WIDTH-1:0]      rsp_cos,
  output logic [ANGLE_WIDTH-1:0]      rsp_angle
);
  import trick_pkg::*;

  logic [NREQ-1:0][ANGLE_WIDTH-1:0] angles;
  logic                   v1, v2;
  req_id_t                id1, id2, last_grant, gnt_id;
  logic [ANGLE_WIDTH-1:0] angle1, angle2;
  logic [VALUE_WIDTH-1:0] sin2, cos2, tab_sin, tab_cos;
  logic                   s1_free, s2_free, accept;

  assign angles = req_angle;

  // On a tie the requester that did not win last time goes next.
  always_comb begin
    if (&req_valid) gnt_id = ~last_grant;
    else            gnt_id = req_valid[REQ_NCO] ? REQ_NCO : REQ_TPG;
  end

  assign s2_free = !v2 || rsp_ready[id2];
  assign s1_free = !v1 || s2_free;
  assign accept  = (|req_valid) && s1_free && !rst;

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[gnt_id] = 1'b1;
  end

  always_comb begin
    rsp_valid = '0;
    if (v2) rsp_valid[id2] = 1'b1;
  end

  assign rsp_sin   = sin2;
  assign rsp_cos   = cos2;
  assign rsp_angle = angle2;

  trick_table #(
    .VALUE_WIDTH(VALUE_WIDTH),
    .ANGLE_WIDTH(ANGLE_WIDTH)
  ) u_table (
    .angle     (angle1),
    .sin_value (tab_sin),
    .cos_value (tab_cos)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      v1         <= 1'b0;
      v2         <= 1'b0;
      id1        <= REQ_NCO;
      id2        <= REQ_NCO;
      angle1     <= '0;
      angle2     <= '0;
      sin2       <= '0;
      cos2       <= '0;
      last_grant <= REQ_TPG;
    end else begin
      // Output data only moves with a real item so a bubble keeps the bus quiet.
      if (s2_free) begin
        v2 <= v1;
        if (v1) begin
          id2    <= id1;
          angle2 <= angle1;
          sin2   <= tab_sin;
          cos2   <= tab_cos;
        end
      end
      if (s1_free) v1 <= accept;
      if (accept) begin
        id1        <= gnt_id;
        angle1     <= angles[gnt_id];
        last_grant <= gnt_id;
      end
    end
  end
endmodule

// File: tb/tb_trick_table_arbiter.sv
// Scoreboard bench: a queue-based model predicts grants, readiness and responses;
// a separate monitor pops expected responses whenever the DUT presents one.
module tb_trick_table_arbiter;
  localparam int  VW  = 33;
  localparam int  AW  = 10;
  localparam int  CNT = 1024;
  localparam real PI  = 3.14159265358979323846;

  logic            clk = 1'b0;
  logic            rst;
  logic [1:0]      req_valid, req_ready, rsp_valid, rsp_ready;
  logic [2*AW-1:0] req_angle;
  logic [VW-1:0]   rsp_sin, rsp_cos;
  logic [AW-1:0]   rsp_angle;

  always #5 clk = ~clk;

  trick_table_arbiter #(.VALUE_WIDTH(VW), .ANGLE_WIDTH(AW), .NREQ(2)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_angle(req_angle), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_sin(rsp_sin), .rsp_cos(rsp_cos), .rsp_angle(rsp_angle)
  );

  typedef struct { int id; int age; } slot_t;
  typedef struct { int id; logic [AW-1:0] angle; logic [VW-1:0] s; logic [VW-1:0] c; } rsp_t;

  slot_t pipe[$];
  rsp_t  exp_q[$];
  int    q0[$];
  int    q1[$];
  bit    acc[2];
  int    last_g;
  int    checks = 0;
  int    failures = 0;

  function automatic logic [VW-1:0] ref_wave(input int a, input bit use_cos);
    real ph;
    real amp;
    ph  = 2.0 * PI * real'(a) / real'(CNT);
    amp = 2.0 ** (VW - 1) - 1.0;
    return VW'(longint'(amp * (use_cos ? $cos(ph) : $sin(ph))));
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Driver: present the head of each requester queue, advance after a handshake.
  always @(posedge clk) begin
    #1;
    if (acc[0]) begin void'(q0.pop_front()); acc[0] = 1'b0; end
    if (acc[1]) begin void'(q1.pop_front()); acc[1] = 1'b0; end
    req_valid[0]          = q0.size() > 0;
    req_valid[1]          = q1.size() > 0;
    req_angle[AW-1:0]     = (q0.size() > 0) ? AW'(q0[0]) : '0;
    req_angle[2*AW-1:AW]  = (q1.size() > 0) ? AW'(q1[0]) : '0;
  end

  // Model: in-order pipeline of at most two items; the head is visible one
  // edge after acceptance; a new item fits when a slot is free or the head leaves.
  always @(negedge clk) begin
    bit         head_vis, consumed, room;
    int         g;
    logic [1:0] exp_rv, exp_rdy;
    logic [AW-1:0] a;
    rsp_t       r;
    #1;
    if (rst) begin
      check("ready_in_reset", req_ready, 2'b00);
      pipe.delete();
      exp_q.delete();
      last_g = 1;
      acc[0] = 1'b0;
      acc[1] = 1'b0;
    end else begin
      head_vis = pipe.size() > 0 && pipe[0].age >= 1;
      exp_rv   = head_vis ? (2'b01 << pipe[0].id) : 2'b00;
      check("rsp_valid", rsp_valid, exp_rv);
      consumed = head_vis && rsp_ready[pipe[0].id];
      room     = pipe.size() < 2 || consumed;
      if (req_valid == 2'b11) g = 1 - last_g;
      else                    g = req_valid[0] ? 0 : 1;
      exp_rdy = (req_valid != 2'b00 && room) ? (2'b01 << g) : 2'b00;
      check("req_ready", req_ready, exp_rdy);
      if (consumed) void'(pipe.pop_front());
      foreach (pipe[k]) pipe[k].age++;
      if (exp_rdy != 2'b00) begin
        a = (g == 0) ? req_angle[AW-1:0] : req_angle[2*AW-1:AW];
        pipe.push_back('{id: g, age: 0});
        r.id = g; r.angle = a; r.s = ref_wave(int'(a), 1'b0); r.c = ref_wave(int'(a), 1'b1);
        exp_q.push_back(r);
        last_g = g;
        acc[g] = 1'b1;
      end
    end
  end

  // Monitor: compare every presented response against the scoreboard head.
  always @(negedge clk) begin
    rsp_t e;
    if (!rst && rsp_valid != 2'b00) begin
      if (exp_q.size() == 0) begin
        check("rsp_unexpected", rsp_valid, 2'b00);
      end else begin
        e = exp_q[0];
        check("rsp_owner", rsp_valid, 2'b01 << e.id);
        check("rsp_angle", rsp_angle, e.angle);
        check("rsp_sin",   rsp_sin,   e.s);
        check("rsp_cos",   rsp_cos,   e.c);
        if (rsp_ready[e.id]) void'(exp_q.pop_front());
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    @(negedge clk);
    check({tag, "_rsp_valid"}, rsp_valid, 2'b00);
    check({tag, "_rsp_sin"},   rsp_sin,   '0);
    check({tag, "_rsp_cos"},   rsp_cos,   '0);
    check({tag, "_rsp_angle"}, rsp_angle, '0);
  endtask

  function automatic int pick_angle();
    case ($urandom_range(3))
      0:       return 0;
      1:       return CNT - 1;
      default: return int'($urandom_range(CNT - 1));
    endcase
  endfunction

  initial begin
    int budget;
    rst = 1'b1;
    req_valid = 2'b00;
    req_angle = '0;
    rsp_ready = 2'b11;
    last_g = 1;
    repeat (2) @(posedge clk);
    check_idle_outputs("reset");
    check("reset_req_ready", req_ready, 2'b00);
    @(posedge clk); #1;
    rst = 1'b0;

    // single request, angle 0
    q0.push_back(0);
    step(5);

    // contention: both requesters stream continuously
    repeat (6) begin q0.push_back(256); q1.push_back(512); end
    step(16);

    // backpressure on requester 0
    rsp_ready = 2'b10;
    for (int a = 1; a <= 4; a++) q0.push_back(a);
    step(5);
    rsp_ready = 2'b11;
    step(8);

    // wrap-around on requester 1
    q1.push_back(CNT - 1);
    q1.push_back(0);
    step(5);

    // ready from the non-owner must not consume the response
    rsp_ready = 2'b10;
    q0.push_back(7);
    step(5);
    rsp_ready = 2'b11;
    step(3);

    // reset with both stages occupied and both requesters waiting
    rsp_ready = 2'b00;
    q0.push_back(100); q0.push_back(101); q0.push_back(102);
    q1.push_back(200); q1.push_back(201);
    step(4);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    check_idle_outputs("midreset");
    @(posedge clk); #1;
    rsp_ready = 2'b11;
    step(12);

    // randomized traffic and backpressure
    repeat (400) begin
      if ($urandom_range(2) == 0 && q0.size() < 3) q0.push_back(pick_angle());
      if ($urandom_range(2) == 0 && q1.size() < 3) q1.push_back(pick_angle());
      rsp_ready = 2'($urandom_range(3));
      step(1);
    end

    rsp_ready = 2'b11;
    budget = 200;
    while ((q0.size() + q1.size() + pipe.size() + exp_q.size()) != 0 && budget > 0) begin
      step(1);
      budget--;
    end
    check("drain_timeout", 64'(budget == 0), 64'(0));
    check("scoreboard_empty", 64'(exp_q.size()), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
